// File: rtl/timebase_pkg.sv
// Shared encodings and constants for the timebase scheduler.
package timebase_pkg;

  typedef enum logic [1:0] {
    TB_US  = 2'b00,
    TB_MS  = 2'b01,
    TB_S   = 2'b10,
    TB_OFF = 2'b11
  } tb_base_e;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_PRESENT = 1'b1
  } arb_state_e;

  localparam int unsigned SUB_PER_UNIT     = 1000;
  localparam int unsigned SUB_W            = $clog2(SUB_PER_UNIT);
  localparam int unsigned DEF_CLK_FREQ_MHZ = 50;

endpackage

// File: rtl/timebase_prescaler.sv
// Cascaded us/ms/s prescaler producing coincident one-cycle tick pulses.
module timebase_prescaler
  import timebase_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  output logic tick_us_o,
  output logic tick_ms_o,
  output logic tick_s_o
);

  localparam int unsigned     PRE_W   = $clog2(CLK_FREQ_MHZ);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_FREQ_MHZ - 1);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SUB_PER_UNIT - 1);

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [SUB_W-1:0] us_cnt_q, us_cnt_d;
  logic [SUB_W-1:0] ms_cnt_q, ms_cnt_d;
  logic             pre_wrap, us_wrap, ms_wrap;

  // Each stage advances on the wrap of the one below, so ticks line up at boundaries.
  always_comb begin
    pre_wrap  = (pre_cnt_q == PRE_MAX);
    us_wrap   = pre_wrap && (us_cnt_q == SUB_MAX);
    ms_wrap   = us_wrap && (ms_cnt_q == SUB_MAX);
    pre_cnt_d = pre_wrap ? '0 : pre_cnt_q + PRE_W'(1);
    us_cnt_d  = us_cnt_q;
    ms_cnt_d  = ms_cnt_q;
    if (pre_wrap) begin
      us_cnt_d = us_wrap ? '0 : us_cnt_q + SUB_W'(1);
    end
    if (us_wrap) begin
      ms_cnt_d = ms_wrap ? '0 : ms_cnt_q + SUB_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pre_cnt_q <= '0;
      us_cnt_q  <= '0;
      ms_cnt_q  <= '0;
      tick_us_o <= 1'b0;
      tick_ms_o <= 1'b0;
      tick_s_o  <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      us_cnt_q  <= us_cnt_d;
      ms_cnt_q  <= ms_cnt_d;
      tick_us_o <= pre_wrap;
      tick_ms_o <= us_wrap;
      tick_s_o  <= ms_wrap;
    end
  end

endmodule

// File: rtl/timebase_sched.sv
// Periodic event scheduler: per-channel period counters on us/ms/s ticks, round-robin event port.
// TIMEBASE_SCHED_TICK_OUT_EN exposes the tick pulses as tick_us/tick_ms/tick_s ports.
module timebase_sched
  import timebase_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = DEF_CLK_FREQ_MHZ,
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                      sys_clk,
  input  logic                      sys_rst_n,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [1:0]                cfg_base,
  input  logic [CNT_W-1:0]          cfg_period,
  output logic                      evt_valid,
  output logic [$clog2(NUM_CH)-1:0] evt_ch,
  input  logic                      evt_ready,
  output logic [NUM_CH-1:0]         overrun
`ifdef TIMEBASE_SCHED_TICK_OUT_EN
  ,
  output logic                      tick_us,
  output logic                      tick_ms,
  output logic                      tick_s
`endif
);

  localparam int unsigned CH_W = $clog2(NUM_CH);

  logic tick_us_w, tick_ms_w, tick_s_w;

  timebase_prescaler #(
    .CLK_FREQ_MHZ(CLK_FREQ_MHZ)
  ) u_prescaler (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .tick_us_o(tick_us_w),
    .tick_ms_o(tick_ms_w),
    .tick_s_o (tick_s_w)
  );

`ifdef TIMEBASE_SCHED_TICK_OUT_EN
  assign tick_us = tick_us_w;
  assign tick_ms = tick_ms_w;
  assign tick_s  = tick_s_w;
`endif

  tb_base_e         base_q   [NUM_CH];
  tb_base_e         base_d   [NUM_CH];
  logic [CNT_W-1:0] period_q [NUM_CH];
  logic [CNT_W-1:0] period_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q    [NUM_CH];
  logic [CNT_W-1:0] cnt_d    [NUM_CH];
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] overrun_q, overrun_d;
  logic [NUM_CH-1:0] sel_tick, expire, hs_clr, avail;

  arb_state_e        state_q, state_d;
  logic              evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   grant;
  logic              hs_c;

  // First requester at or after start, wrapping; NUM_CH is a power of two.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   start);
    logic [CH_W-1:0] idx;
    rr_pick = start;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = start + CH_W'(i);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

  assign hs_c = evt_valid_q && evt_ready;

  // Channel counters, pending/overrun tracking and config writes (write wins).
  always_comb begin
    sel_tick  = '0;
    expire    = '0;
    hs_clr    = '0;
    pending_d = pending_q;
    overrun_d = overrun_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      base_d[ch]   = base_q[ch];
      period_d[ch] = period_q[ch];
      cnt_d[ch]    = cnt_q[ch];
      unique case (base_q[ch])
        TB_US:   sel_tick[ch] = tick_us_w;
        TB_MS:   sel_tick[ch] = tick_ms_w;
        TB_S:    sel_tick[ch] = tick_s_w;
        default: sel_tick[ch] = 1'b0;
      endcase
      hs_clr[ch] = hs_c && (evt_ch_q == CH_W'(ch));
      if (sel_tick[ch] && (period_q[ch] != '0)) begin
        if (cnt_q[ch] == period_q[ch] - CNT_W'(1)) begin
          cnt_d[ch]  = '0;
          expire[ch] = 1'b1;
        end else begin
          cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
        end
      end
      pending_d[ch] = (pending_q[ch] & ~hs_clr[ch]) | expire[ch];
      overrun_d[ch] = overrun_q[ch] | (expire[ch] & pending_q[ch] & ~hs_clr[ch]);
      if (cfg_we && (cfg_ch == CH_W'(ch))) begin
        base_d[ch]    = tb_base_e'(cfg_base);
        period_d[ch]  = cfg_period;
        cnt_d[ch]     = '0;
        pending_d[ch] = 1'b0;
        overrun_d[ch] = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        base_q[ch]   <= TB_OFF;
        period_q[ch] <= '0;
        cnt_q[ch]    <= '0;
      end
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      base_q    <= base_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

  // Arbiter: the accepted channel is masked so a re-grant goes to another requester.
  always_comb begin
    state_d     = state_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    rr_ptr_d    = rr_ptr_q;
    avail       = pending_q & ~hs_clr;
    grant       = rr_pick(avail, rr_ptr_q);
    unique case (state_q)
      ARB_IDLE: begin
        if (|avail) begin
          state_d     = ARB_PRESENT;
          evt_valid_d = 1'b1;
          evt_ch_d    = grant;
          rr_ptr_d    = grant + CH_W'(1);
        end
      end
      ARB_PRESENT: begin
        if (hs_c) begin
          if (|avail) begin
            evt_ch_d = grant;
            rr_ptr_d = grant + CH_W'(1);
          end else begin
            state_d     = ARB_IDLE;
            evt_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        evt_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ARB_IDLE;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_timebase_sched.sv
// Scoreboard bench for timebase_sched: arithmetic tick/expiry model feeds an expected-event queue.
module tb_timebase_sched;

  localparam int F  = 50;
  localparam int N  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [1:0]    cfg_base;
  logic [CW-1:0] cfg_period;
  logic          evt_valid;
  logic [1:0]    evt_ch;
  logic          evt_ready;
  logic [N-1:0]  overrun;
`ifdef TIMEBASE_SCHED_TICK_OUT_EN
  logic tick_us, tick_ms, tick_s;
`endif

  timebase_sched #(.CLK_FREQ_MHZ(F), .NUM_CH(N), .CNT_W(CW)) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_base  (cfg_base),
    .cfg_period(cfg_period),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .evt_ready (evt_ready),
    .overrun   (overrun)
`ifdef TIMEBASE_SCHED_TICK_OUT_EN
    ,
    .tick_us   (tick_us),
    .tick_ms   (tick_ms),
    .tick_s    (tick_s)
`endif
  );

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;
  bit   sb_on = 1'b0;
  int   seen_valid = 0;

  // Reference configuration: base, period and the cycle each channel was written.
  int m_base[N];
  int m_per[N];
  int m_w[N];
  int m_ptr;

  always #5 clk = ~clk;

  // Cycle n = the clock period after the n-th rising edge following reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int base_div(input int b);
    case (b)
      0:       return F;
      1:       return F * 1000;
      default: return F * 1000000;
    endcase
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N; c++) begin
      m_base[c] = 3;
      m_per[c]  = 0;
      m_w[c]    = 0;
    end
    m_ptr = 0;
    q.delete();
  endtask

  // Push every event caused by ticks in cycles (lo, hi]; consumer always ready.
  task automatic model_run(input int lo, input int hi);
    int       div, cnt, k, last, c;
    bit [N-1:0] hit;
    exp_t     e;
    for (int t = (lo / F + 1) * F; t <= hi; t += F) begin
      hit = '0;
      for (int ch = 0; ch < N; ch++) begin
        if (m_base[ch] != 3 && m_per[ch] != 0) begin
          div = base_div(m_base[ch]);
          if (t % div == 0 && t > m_w[ch]) begin
            cnt = t / div - m_w[ch] / div;
            if (cnt % m_per[ch] == 0) hit[ch] = 1'b1;
          end
        end
      end
      k = 0;
      last = 0;
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (hit[c]) begin
          e.ch  = c;
          e.cyc = t + 2 + k;
          q.push_back(e);
          k++;
          last = c;
        end
      end
      if (k > 0) m_ptr = (last + 1) % N;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after a rising edge; the strobe is high for exactly that cycle.
  task automatic cfg_write(input int ch, input int b, input int per);
    cfg_we     = 1'b1;
    cfg_ch     = 2'(ch);
    cfg_base   = 2'(b);
    cfg_period = CW'(per);
    m_base[ch] = b;
    m_per[ch]  = per;
    m_w[ch]    = cyc;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  task automatic do_reset();
    sb_on = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  // Scoreboard monitor: every accepted event must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && sb_on && evt_valid) begin
      seen_valid++;
      if (evt_ready) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_evt", int'(evt_ch), -1);
        end else begin
          mon_e = q.pop_front();
          check(int'(evt_ch) == mon_e.ch, "evt_ch", int'(evt_ch), mon_e.ch);
          check(cyc == mon_e.cyc, "evt_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad, s, hi, nw, r, b;
    rst_n      = 1'b0;
    cfg_we     = 1'b0;
    cfg_ch     = '0;
    cfg_base   = '0;
    cfg_period = '0;
    evt_ready  = 1'b1;
    model_clear();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check(evt_valid == 1'b0, "rst_evt_valid", int'(evt_valid), 0);
    check(evt_ch == 2'd0, "rst_evt_ch", int'(evt_ch), 0);
    check(overrun == '0, "rst_overrun", int'(overrun), 0);

    // Prescaler timing plus single-channel periodic service, through the first ms tick
    do_reset();
    sb_on = 1'b1;
    wait_until(20);
    cfg_write(0, 0, 3);
    cfg_write(1, 1, 1);
    cfg_write(2, 0, 1);
    model_run(20, 50000);
    wait_until(50010);
    check(q.size() == 0, "phaseA_missing_events", q.size(), 0);
    check(overrun == '0, "phaseA_overrun", int'(overrun), 0);

    // Round robin between two channels expiring together
    do_reset();
    sb_on = 1'b1;
    wait_until(20);
    cfg_write(0, 0, 1);
    cfg_write(1, 0, 1);
    model_run(20, 500);
    wait_until(510);
    check(q.size() == 0, "rr_missing_events", q.size(), 0);
    check(overrun == '0, "rr_overrun", int'(overrun), 0);

    // Backpressure, overrun, config clear, then reset while presenting
    do_reset();
    evt_ready = 1'b0;
    wait_until(20);
    cfg_write(2, 0, 1);
    wait_until(51);
    check(evt_valid == 1'b0, "bp_valid_before_expiry", int'(evt_valid), 0);
    wait_until(52);
    check(evt_valid == 1'b1, "bp_first_valid", int'(evt_valid), 1);
    check(evt_ch == 2'd2, "bp_first_ch", int'(evt_ch), 2);
    bad = 0;
    while (cyc < 100) begin
      @(posedge clk);
      #1;
      if (!(evt_valid && evt_ch == 2'd2)) bad++;
    end
    check(overrun == 4'b0000, "bp_overrun_before_2nd", int'(overrun), 0);
    wait_until(101);
    check(overrun == 4'b0100, "bp_overrun_after_2nd", int'(overrun), 4);
    while (cyc < 220) begin
      @(posedge clk);
      #1;
      if (!(evt_valid && evt_ch == 2'd2)) bad++;
    end
    check(bad == 0, "bp_held_stable_cycles_bad", bad, 0);
    cfg_write(2, 0, 1);
    check(overrun == 4'b0000, "cfg_clears_overrun", int'(overrun), 0);
    check(evt_valid == 1'b1, "cfg_keeps_valid", int'(evt_valid), 1);
    check(evt_ch == 2'd2, "cfg_keeps_ch", int'(evt_ch), 2);
    evt_ready = 1'b1;
    wait_until(222);
    check(evt_valid == 1'b0, "bp_idle_after_accept", int'(evt_valid), 0);
    evt_ready = 1'b0;
    wait_until(252);
    check(evt_valid == 1'b1, "bp_restart_valid", int'(evt_valid), 1);
    check(evt_ch == 2'd2, "bp_restart_ch", int'(evt_ch), 2);
    wait_until(301);
    check(overrun == 4'b0100, "bp_overrun_again", int'(overrun), 4);
    #3;
    rst_n = 1'b0;
    #1;
    check(evt_valid == 1'b0, "async_rst_valid", int'(evt_valid), 0);
    check(overrun == 4'b0000, "async_rst_overrun", int'(overrun), 0);
    check(evt_ch == 2'd0, "async_rst_ch", int'(evt_ch), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    evt_ready  = 1'b1;
    seen_valid = 0;
    sb_on      = 1'b1;
    wait_until(400);
    check(seen_valid == 0, "post_rst_all_disabled", seen_valid, 0);

    // Disabled channels: zero period or off base never fire
    do_reset();
    sb_on      = 1'b1;
    seen_valid = 0;
    wait_until(20);
    cfg_write(0, 0, 0);
    cfg_write(1, 3, 5);
    cfg_write(2, 3, 0);
    cfg_write(3, 1, 0);
    model_run(20, 5000);
    wait_until(5010);
    check(seen_valid == 0, "disabled_valid_cycles", seen_valid, 0);
    check(overrun == '0, "disabled_overrun", int'(overrun), 0);

    // Randomized reconfiguration segments, writes placed away from tick cycles
    do_reset();
    sb_on = 1'b1;
    s  = 20;
    hi = 0;
    for (int seg = 0; seg < 8; seg++) begin
      wait_until(s);
      nw = $urandom_range(1, N);
      for (int k = 0; k < nw; k++) begin
        r = $urandom_range(0, 9);
        b = (r < 7) ? 0 : (r == 7) ? 1 : (r == 8) ? 3 : 2;
        cfg_write($urandom_range(0, N - 1), b, $urandom_range(0, 5));
      end
      hi = s - 20 + F * $urandom_range(4, 12);
      model_run(s, hi);
      s = hi + 20;
    end
    wait_until(hi + 10);
    check(q.size() == 0, "rand_missing_events", q.size(), 0);
    check(overrun == '0, "rand_overrun", int'(overrun), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
